// File: rtl/enemy_fleet_ctrl.sv
// enemy_fleet_ctrl: frame-rate march/descend controller for the alien formation.
// Optional: define ENEMY_FLEET_LOWEST_ROW_EN to measure invasion from the lowest live row.
module enemy_fleet_ctrl #(
  parameter int COLS         = 8,
  parameter int ROWS         = 4,
  parameter int PITCH_X      = 48,
  parameter int PITCH_Y      = 40,
  parameter int ALIEN_W      = 32,
  parameter int ALIEN_H      = 32,
  parameter int FLEET_X0     = 100,
  parameter int FLEET_Y0     = 40,
  parameter int LEFT_BOUND   = 16,
  parameter int RIGHT_BOUND  = 624,
  parameter int BOTTOM_LIMIT = 420,
  parameter int DROP_FRAMES  = 8
) (
  input  logic                          frame_clk,
  input  logic                          Reset,
  input  logic                          start,
  input  logic                          hit_valid,
  input  logic [$clog2(ROWS*COLS)-1:0]  hit_index,
  output logic                          enemy_direction_X,
  output logic                          enemy_direction_Y,
  output logic                          fleet_run,
  output logic                          delete_enemies,
  output logic [ROWS*COLS-1:0]          alive_mask,
  output logic [9:0]                    fleet_x,
  output logic [9:0]                    fleet_y,
  output logic                          fleet_cleared,
  output logic                          fleet_invaded
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = (DROP_FRAMES > 1) ? $clog2(DROP_FRAMES) : 1;

  localparam logic [10:0] L_PX = 11'(PITCH_X);
  localparam logic [10:0] L_AW = 11'(ALIEN_W);
  localparam logic [10:0] L_LB = 11'(LEFT_BOUND);
  localparam logic [10:0] L_RB = 11'(RIGHT_BOUND);
  localparam logic [10:0] L_BL = 11'(BOTTOM_LIMIT);

  typedef enum logic [2:0] {S_IDLE, S_MARCH, S_DESCEND, S_CLEARED, S_INVADED} state_t;

  state_t          r_state;
  logic [DW-1:0]   r_drop_cnt;
  logic            r_dir_x, r_dir_y, r_run, r_delete, r_cleared, r_invaded;
  logic [N-1:0]    r_alive;
  logic [9:0]      r_fleet_x, r_fleet_y;

  logic [COLS-1:0] w_col_any;
  logic [CW-1:0]   w_lcol, w_rcol;
  logic [10:0]     w_left_edge, w_right_edge, w_bottom_edge;
  logic            w_wall, w_idx_ok, w_hit_ok, w_active;

  always_comb begin
    w_col_any = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r_alive[r*COLS+c]) w_col_any[c] = 1'b1;
    w_lcol = '0;
    for (int c = COLS - 1; c >= 0; c--)
      if (w_col_any[c]) w_lcol = CW'(c);
    w_rcol = '0;
    for (int c = 0; c < COLS; c++)
      if (w_col_any[c]) w_rcol = CW'(c);
  end

  assign w_left_edge  = {1'b0, r_fleet_x} + 11'(w_lcol) * L_PX;
  assign w_right_edge = {1'b0, r_fleet_x} + 11'(w_rcol) * L_PX + L_AW;

`ifdef ENEMY_FLEET_LOWEST_ROW_EN
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [10:0] L_PY = 11'(PITCH_Y);
  localparam logic [10:0] L_AH = 11'(ALIEN_H);
  logic [ROWS-1:0] w_row_any;
  logic [RW-1:0]   w_brow;

  always_comb begin
    w_row_any = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r_alive[r*COLS+c]) w_row_any[r] = 1'b1;
    w_brow = '0;
    for (int r = 0; r < ROWS; r++)
      if (w_row_any[r]) w_brow = RW'(r);
  end

  assign w_bottom_edge = {1'b0, r_fleet_y} + 11'(w_brow) * L_PY + L_AH;
`else
  localparam logic [10:0] L_FULL_H = 11'((ROWS - 1) * PITCH_Y + ALIEN_H);
  assign w_bottom_edge = {1'b0, r_fleet_y} + L_FULL_H;
`endif

  // A full power-of-two index range cannot go out of bounds.
  if (N == (1 << IW)) begin : g_idx_full
    assign w_idx_ok = 1'b1;
  end else begin : g_idx_chk
    assign w_idx_ok = (32'(hit_index) < 32'(N));
  end

  assign w_active = (r_state == S_MARCH) || (r_state == S_DESCEND);
  assign w_hit_ok = hit_valid && w_idx_ok && w_active;
  assign w_wall   = r_dir_x ? (w_right_edge >= L_RB) : (w_left_edge <= L_LB);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_drop_cnt <= '0;
      r_dir_x    <= 1'b1;
      r_dir_y    <= 1'b0;
      r_run      <= 1'b0;
      r_delete   <= 1'b0;
      r_cleared  <= 1'b0;
      r_invaded  <= 1'b0;
      r_alive    <= '1;
      r_fleet_x  <= 10'(FLEET_X0);
      r_fleet_y  <= 10'(FLEET_Y0);
    end else begin
      // Mirror the sprites: they move on this edge using the commands already output.
      if (r_run) begin
        r_fleet_x <= r_dir_x ? r_fleet_x + 10'd1 : r_fleet_x - 10'd1;
        if (r_dir_y) r_fleet_y <= r_fleet_y + 10'd1;
      end
      if (w_hit_ok) r_alive[hit_index] <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_MARCH;
            r_run   <= 1'b1;
            r_dir_y <= 1'b0;
          end
        end
        S_MARCH, S_DESCEND: begin
          if (r_alive == '0) begin
            r_state   <= S_CLEARED;
            r_run     <= 1'b0;
            r_dir_y   <= 1'b0;
            r_cleared <= 1'b1;
            r_delete  <= 1'b1;
          end else if (w_bottom_edge >= L_BL) begin
            r_state   <= S_INVADED;
            r_run     <= 1'b0;
            r_dir_y   <= 1'b0;
            r_invaded <= 1'b1;
            r_delete  <= 1'b1;
          end else if (r_state == S_MARCH) begin
            if (w_wall) begin
              r_dir_x    <= ~r_dir_x;
              r_dir_y    <= 1'b1;
              r_drop_cnt <= DW'(DROP_FRAMES - 1);
              r_state    <= S_DESCEND;
            end
          end else if (r_drop_cnt == '0) begin
            r_dir_y <= 1'b0;
            r_state <= S_MARCH;
          end else begin
            r_drop_cnt <= r_drop_cnt - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign enemy_direction_X = r_dir_x;
  assign enemy_direction_Y = r_dir_y;
  assign fleet_run         = r_run;
  assign delete_enemies    = r_delete;
  assign alive_mask        = r_alive;
  assign fleet_x           = r_fleet_x;
  assign fleet_y           = r_fleet_y;
  assign fleet_cleared     = r_cleared;
  assign fleet_invaded     = r_invaded;
endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// Scoreboard bench for enemy_fleet_ctrl: a frame-level model predicts every output word.
module tb_enemy_fleet_ctrl;
  logic        clk = 1'b0;
  logic        Reset = 1'b1, start = 1'b0, hit_valid = 1'b0;
  logic [4:0]  hit_index = '0;
  logic        enemy_direction_X, enemy_direction_Y, fleet_run, delete_enemies;
  logic [31:0] alive_mask;
  logic [9:0]  fleet_x, fleet_y;
  logic        fleet_cleared, fleet_invaded;

  always #5 clk = ~clk;

  enemy_fleet_ctrl dut (
    .frame_clk(clk), .Reset(Reset), .start(start), .hit_valid(hit_valid), .hit_index(hit_index),
    .enemy_direction_X(enemy_direction_X), .enemy_direction_Y(enemy_direction_Y),
    .fleet_run(fleet_run), .delete_enemies(delete_enemies), .alive_mask(alive_mask),
    .fleet_x(fleet_x), .fleet_y(fleet_y), .fleet_cleared(fleet_cleared), .fleet_invaded(fleet_invaded)
  );

  typedef struct packed {
    logic run, dx, dy, del;
    logic [31:0] mask;
    logic [9:0] x, y;
    logic clr, inv;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Frame-level reference: position, heading, descent frames left, alive set.
  localparam int MD_IDLE = 0, MD_MARCH = 1, MD_DESC = 2, MD_DONE = 3;
  int m_mode, m_x, m_y, m_rem;
  bit m_dx, m_dy, m_run, m_del, m_clr, m_inv;
  bit m_alive[32];

  task automatic model_step(input bit rst, input bit st, input bit hv, input int hi);
    int lcol, rcol, brow, left, right, bottom;
    bit any, wall, odx, ody, orun;
    exp_t x;
    if (rst) begin
      m_mode = MD_IDLE; m_x = 100; m_y = 40; m_rem = 0;
      m_dx = 1; m_dy = 0; m_run = 0; m_del = 0; m_clr = 0; m_inv = 0;
      for (int i = 0; i < 32; i++) m_alive[i] = 1;
    end else begin
      lcol = 99; rcol = -1; brow = -1; any = 0;
      for (int i = 0; i < 32; i++)
        if (m_alive[i]) begin
          any = 1;
          if (i % 8 < lcol) lcol = i % 8;
          if (i % 8 > rcol) rcol = i % 8;
          if (i / 8 > brow) brow = i / 8;
        end
      left  = m_x + lcol * 48;
      right = m_x + rcol * 48 + 32;
`ifdef ENEMY_FLEET_LOWEST_ROW_EN
      bottom = m_y + brow * 40 + 32;
`else
      bottom = m_y + 3 * 40 + 32;
`endif
      wall = m_dx ? (right >= 624) : (left <= 16);
      odx = m_dx; ody = m_dy; orun = m_run;
      if (orun) begin
        m_x = odx ? m_x + 1 : m_x - 1;
        if (ody) m_y = m_y + 1;
      end
      if ((m_mode == MD_MARCH || m_mode == MD_DESC) && hv && hi < 32) m_alive[hi] = 0;
      if (m_mode == MD_IDLE) begin
        if (st) begin m_mode = MD_MARCH; m_run = 1; end
      end else if (m_mode != MD_DONE) begin
        if (!any) begin
          m_mode = MD_DONE; m_run = 0; m_dy = 0; m_clr = 1; m_del = 1;
        end else if (bottom >= 420) begin
          m_mode = MD_DONE; m_run = 0; m_dy = 0; m_inv = 1; m_del = 1;
        end else if (m_mode == MD_MARCH) begin
          if (wall) begin m_dx = !m_dx; m_dy = 1; m_rem = 8; m_mode = MD_DESC; end
        end else begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin m_dy = 0; m_mode = MD_MARCH; end
        end
      end
    end
    x.run = m_run; x.dx = m_dx; x.dy = m_dy; x.del = m_del;
    for (int i = 0; i < 32; i++) x.mask[i] = m_alive[i];
    x.x = 10'(m_x); x.y = 10'(m_y); x.clr = m_clr; x.inv = m_inv;
    q.push_back(x);
  endtask

  // One frame: drive on the falling edge, predict, then let the rising edge land.
  task automatic tick(input bit rst, input bit st, input bit hv, input logic [4:0] hi);
    @(negedge clk);
    Reset = rst; start = st; hit_valid = hv; hit_index = hi;
    model_step(rst, st, hv, int'(hi));
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("sb_run",  fleet_run,         e.run);
      cmp("sb_dirx", enemy_direction_X, e.dx);
      cmp("sb_diry", enemy_direction_Y, e.dy);
      cmp("sb_del",  delete_enemies,    e.del);
      cmp("sb_mask", alive_mask,        e.mask);
      cmp("sb_x",    fleet_x,           e.x);
      cmp("sb_y",    fleet_y,           e.y);
      cmp("sb_clr",  fleet_cleared,     e.clr);
      cmp("sb_inv",  fleet_invaded,     e.inv);
    end
  end

  initial begin
    // First wall contact with a full fleet.
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    cmp("rst_dirx", enemy_direction_X, 1);
    cmp("rst_run", fleet_run, 0);
    cmp("rst_x", fleet_x, 100);
    cmp("rst_y", fleet_y, 40);
    cmp("rst_mask", alive_mask, 32'hFFFF_FFFF);
    repeat (3) tick(0, 0, 1, 5'($urandom_range(0, 31)));
    cmp("idle_hit_ignored", alive_mask, 32'hFFFF_FFFF);
    tick(0, 1, 0, 0);
    cmp("start_run", fleet_run, 1);
    repeat (156) tick(0, 0, 0, 0);
    cmp("wall1_x", fleet_x, 256);
    cmp("wall1_dirx_pre", enemy_direction_X, 1);
    tick(0, 0, 0, 0);
    cmp("wall1_dirx", enemy_direction_X, 0);
    cmp("wall1_diry", enemy_direction_Y, 1);
    repeat (7) tick(0, 0, 0, 0);
    cmp("desc7_diry", enemy_direction_Y, 1);
    cmp("desc7_y", fleet_y, 47);
    tick(0, 0, 0, 0);
    cmp("desc8_diry", enemy_direction_Y, 0);
    cmp("desc8_y", fleet_y, 48);

    // Column 7 removed, duplicate hit on index 5, then full clear.
    tick(1, 0, 0, 0); tick(0, 1, 0, 0);
    tick(0, 0, 1, 7); tick(0, 0, 1, 15); tick(0, 0, 1, 23); tick(0, 0, 1, 31);
    tick(0, 0, 1, 5); tick(0, 0, 1, 5);
    cmp("mask_after_hits", alive_mask, 32'h7F7F_7F5F);
    repeat (198) tick(0, 0, 0, 0);
    cmp("wall2_x", fleet_x, 304);
    cmp("wall2_dirx_pre", enemy_direction_X, 1);
    tick(0, 0, 0, 0);
    cmp("wall2_dirx", enemy_direction_X, 0);
    for (int i = 31; i >= 0; i--) tick(0, 0, 1, 5'(i));
    cmp("clear_mask", alive_mask, 0);
    cmp("clear_pre_flag", fleet_cleared, 0);
    tick(0, 1, 1, 3);
    cmp("cleared", fleet_cleared, 1);
    cmp("cleared_del", delete_enemies, 1);
    cmp("cleared_run", fleet_run, 0);
    repeat (5) tick(0, 1, 1, 5'($urandom_range(0, 31)));
    cmp("cleared_hold", fleet_cleared, 1);

    // Reset in the middle of a descent.
    tick(1, 0, 0, 0); tick(0, 1, 0, 0);
    repeat (161) tick(0, 0, 0, 0);
    cmp("mid_desc_diry", enemy_direction_Y, 1);
    tick(1, 0, 0, 0);
    cmp("mid_rst_diry", enemy_direction_Y, 0);
    cmp("mid_rst_dirx", enemy_direction_X, 1);
    cmp("mid_rst_run", fleet_run, 0);
    cmp("mid_rst_x", fleet_x, 100);
    cmp("mid_rst_y", fleet_y, 40);

    // March down to the invasion line.
    tick(0, 1, 0, 0);
`ifdef ENEMY_FLEET_LOWEST_ROW_EN
    for (int i = 24; i < 32; i++) tick(0, 0, 1, 5'(i));
`endif
    for (int i = 0; i < 12000 && !fleet_invaded; i++) tick(0, 0, 0, 0);
    cmp("invaded", fleet_invaded, 1);
    cmp("invaded_del", delete_enemies, 1);
    cmp("invaded_run", fleet_run, 0);
`ifdef ENEMY_FLEET_LOWEST_ROW_EN
    cmp("invaded_y", fleet_y, 309);
`else
    cmp("invaded_y", fleet_y, 269);
`endif

    // Random traffic: sparse hits first, then dense hits.
    tick(1, 0, 0, 0);
    for (int i = 0; i < 6000; i++)
      tick($urandom_range(0, 2499) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 59) == 0, 5'($urandom_range(0, 31)));
    tick(1, 0, 0, 0); tick(0, 1, 0, 0);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 1499) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));

    repeat (2) @(posedge clk);
    #3;
    cmp("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
